// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: shared state type, widths and helpers for the frequency counter
package freq_counter_pkg;
   typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;
   localparam int FREQ_W = 32;
   localparam int MAX_PROD_W = 128;
   function automatic int prod_w(input int cnt_w, input int ref_hz);
      return cnt_w + $clog2(ref_hz + 1);
   endfunction
   function automatic logic [FREQ_W-1:0] sat_freq(input logic [MAX_PROD_W-1:0] v);
      return (|v[MAX_PROD_W-1:FREQ_W]) ? {FREQ_W{1'b1}} : v[FREQ_W-1:0];
   endfunction
endpackage

// File: rtl/freq_counter_mc_chan.sv
// freq_chan: one measured input (synchroniser, rising-edge detector, saturating edge counter, sticky overflow, snapshot)
//   ref_clk, rst_ : clock, async active-low reset
//   targ          : asynchronous target input
//   arm           : enables edge detection once the synchroniser has flushed after reset
//   count_en      : count edges (gate window active)
//   snap          : copy count and overflow (including this cycle's edge) into the snapshot
//   clr           : clear live count and overflow
//   snap_cnt/ovf  : snapshot outputs
module freq_chan #(
   parameter int CNT_W = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             ref_clk,
   input  logic             rst_,
   input  logic             targ,
   input  logic             arm,
   input  logic             count_en,
   input  logic             snap,
   input  logic             clr,
   output logic [CNT_W-1:0] snap_cnt,
   output logic             snap_ovf
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d, next_cnt;
   logic ovf_q, ovf_d, snap_ovf_q, snap_ovf_d, next_ovf, rise, at_max;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], targ};
      prev_d = sync_q[SYNC_STAGES-1];
      rise = arm & sync_q[SYNC_STAGES-1] & ~prev_q;
      at_max = &cnt_q;
      // an edge arriving at full scale is dropped and flagged instead of wrapping
      next_cnt = (count_en & rise & ~at_max) ? cnt_q + CNT_W'(1) : cnt_q;
      next_ovf = ovf_q | (count_en & rise & at_max);
      cnt_d = clr ? '0 : next_cnt;
      ovf_d = clr ? 1'b0 : next_ovf;
      snap_d = snap ? next_cnt : snap_q;
      snap_ovf_d = snap ? next_ovf : snap_ovf_q;
   end
   always_ff @(posedge ref_clk or negedge rst_) begin
      if (!rst_) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         snap_q <= '0;
         snap_ovf_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         snap_q <= snap_d;
         snap_ovf_q <= snap_ovf_d;
      end
   end
   assign snap_cnt = snap_q;
   assign snap_ovf = snap_ovf_q;
endmodule

// File: rtl/freq_counter_mc.sv
// freq_counter_mc: multi-channel gated edge counter with conversion to hertz
//   ref_clk, rst_ : sole clock, async active-low reset
//   en, mode      : enable (low aborts a window); 0 continuous, 1 single-shot
//   start         : single-shot trigger, honoured in IDLE only
//   targ_in       : asynchronous target inputs, one per channel
//   freq          : per-channel result in Hz, channel i at [32i+31:32i]
//   freq_valid    : sticky, set by the first result
//   done          : one-cycle pulse when freq updates
//   busy          : gate window active
//   ovf           : per-channel counter saturation in the last window
module freq_counter_mc import freq_counter_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 32,
   parameter int REF_HZ = 10_000_000,
   parameter int GATE_LOG2 = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       ref_clk,
   input  logic                       rst_,
   input  logic                       en,
   input  logic                       mode,
   input  logic                       start,
   input  logic [CHANNELS-1:0]        targ_in,
   output logic [FREQ_W*CHANNELS-1:0] freq,
   output logic                       freq_valid,
   output logic                       done,
   output logic                       busy,
   output logic [CHANNELS-1:0]        ovf
);
   localparam int PROD_W = prod_w(CNT_W, REF_HZ);
   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   state_t state_q, state_d;
   logic [GATE_LOG2-1:0] gate_q, gate_d;
   logic [ARM_W-1:0] arm_q, arm_d;
   logic conv_q, conv_d, done_q, done_d, valid_q, valid_d;
   logic [FREQ_W*CHANNELS-1:0] freq_q, freq_d;
   logic [CHANNELS-1:0] ovf_q, ovf_d, snap_ovf;
   logic [CNT_W*CHANNELS-1:0] snap_cnt;
   logic arm, in_gate, terminal, abort;
   function automatic logic [FREQ_W-1:0] to_hz(input logic [CNT_W-1:0] c);
      logic [PROD_W-1:0] p;
      p = PROD_W'(c) * PROD_W'(REF_HZ);
      return sat_freq(MAX_PROD_W'(p >> GATE_LOG2));
   endfunction
   // edges stay masked until the synchroniser and previous-level flop hold post-reset data
   assign arm = (arm_q == ARM_W'(SYNC_STAGES + 1));
   assign in_gate = (state_q == GATE);
   assign terminal = in_gate & en & (&gate_q);
   assign abort = in_gate & ~en;
   always_comb begin
      state_d = in_gate ? ((abort || (terminal && mode)) ? IDLE : GATE)
                        : ((en && (!mode || start)) ? GATE : IDLE);
      gate_d = (in_gate & en) ? gate_q + GATE_LOG2'(1) : '0;
      arm_d = arm ? arm_q : arm_q + ARM_W'(1);
      conv_d = terminal;
      done_d = conv_q;
      valid_d = valid_q | conv_q;
      ovf_d = conv_q ? snap_ovf : ovf_q;
      freq_d = freq_q;
      for (int i = 0; i < CHANNELS; i++)
         if (conv_q) freq_d[FREQ_W*i +: FREQ_W] = to_hz(snap_cnt[CNT_W*i +: CNT_W]);
   end
   always_ff @(posedge ref_clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= IDLE;
         gate_q <= '0;
         arm_q <= '0;
         conv_q <= 1'b0;
         done_q <= 1'b0;
         valid_q <= 1'b0;
         freq_q <= '0;
         ovf_q <= '0;
      end else begin
         state_q <= state_d;
         gate_q <= gate_d;
         arm_q <= arm_d;
         conv_q <= conv_d;
         done_q <= done_d;
         valid_q <= valid_d;
         freq_q <= freq_d;
         ovf_q <= ovf_d;
      end
   end
   genvar c;
   for (c = 0; c < CHANNELS; c++) begin : g_chan
      freq_chan #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_chan (
         .ref_clk  (ref_clk),
         .rst_     (rst_),
         .targ     (targ_in[c]),
         .arm      (arm),
         .count_en (in_gate),
         .snap     (terminal),
         .clr      (terminal | abort),
         .snap_cnt (snap_cnt[CNT_W*c +: CNT_W]),
         .snap_ovf (snap_ovf[c])
      );
   end
   assign freq = freq_q;
   assign freq_valid = valid_q;
   assign done = done_q;
   assign busy = in_gate;
   assign ovf = ovf_q;
endmodule

// File: tb/tb_freq_counter_mc.sv
// tb_freq_counter_mc: directed bench for freq_counter_mc with a 256-cycle gate and a 6-bit-counter twin
module tb_freq_counter_mc;
   localparam int CH = 4;
   logic clk = 1'b0, rst_ = 1'b0, en = 1'b0, mode = 1'b0, start = 1'b0, pat_on = 1'b0;
   logic [CH-1:0] targ = '0, hold = '0, targ6;
   logic [32*CH-1:0] freq, freq6;
   logic freq_valid, done, busy, valid6, done6, busy6;
   logic [CH-1:0] ovf, ovf6;
   int ph = 0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   // ch0 period 4, ch1 period 8, ch2 period 2, ch3 constant 0
   initial forever begin
      @(negedge clk);
      ph++;
      targ = pat_on ? {1'b0, ph[0], ph[2], ph[1]} : hold;
   end
   assign targ6 = {3'b000, targ[2]};
   freq_counter_mc #(.CHANNELS(CH), .CNT_W(32), .REF_HZ(10_000_000), .GATE_LOG2(8), .SYNC_STAGES(2)) dut (
      .ref_clk(clk), .rst_(rst_), .en(en), .mode(mode), .start(start), .targ_in(targ),
      .freq(freq), .freq_valid(freq_valid), .done(done), .busy(busy), .ovf(ovf));
   freq_counter_mc #(.CHANNELS(CH), .CNT_W(6), .REF_HZ(10_000_000), .GATE_LOG2(8), .SYNC_STAGES(2)) dut6 (
      .ref_clk(clk), .rst_(rst_), .en(en), .mode(mode), .start(start), .targ_in(targ6),
      .freq(freq6), .freq_valid(valid6), .done(done6), .busy(busy6), .ovf(ovf6));
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic wait_done(input string tag, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < limit);
      checks++;
      assert (done === 1'b1) else begin
         errors++;
         $error("FAIL %s done=%b expected 1 within %0d cycles", tag, done, limit);
      end
   endtask
   initial begin
      int n, busy_n, done_n, done_at;
      repeat (3) @(negedge clk);
      chk("rst_freq", freq, '0);
      chk("rst_flags", 128'({freq_valid, done, busy, ovf}), '0);
      rst_ = 1'b1;
      en = 1'b1;
      pat_on = 1'b1;
      wait_done("cont_first", 600, n);
      wait_done("cont_second", 300, n);
      chk("cont_period", 128'(n), 128'(256));
      chk("cont_freq", freq, {32'd0, 32'd5_000_000, 32'd1_250_000, 32'd2_500_000});
      chk("cont_ovf", 128'(ovf), '0);
      chk("cont_valid", 128'(freq_valid), 128'(1));
      chk("sat_freq", freq6, {96'd0, 32'd2_460_937});
      chk("sat_ovf", 128'(ovf6), 128'(4'b0001));
      chk("sat_flags", 128'({done6, valid6, busy6}), 128'(3'b111));
      @(negedge clk);
      chk("done_pulse", 128'(done), '0);
      repeat (98) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("abort_busy", 128'(busy), '0);
      done_n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done) done_n++;
      end
      chk("abort_no_done", 128'(done_n), '0);
      chk("abort_hold", 128'({freq_valid, freq[31:0]}), 128'({1'b1, 32'd2_500_000}));
      en = 1'b1;
      wait_done("restart", 600, n);
      chk("restart_latency", 128'(n), 128'(258));
      chk("restart_freq", freq, {32'd0, 32'd5_000_000, 32'd1_250_000, 32'd2_500_000});
      mode = 1'b1;
      wait_done("mode_switch", 300, n);
      chk("mode_switch_period", 128'(n), 128'(256));
      chk("mode_switch_idle", 128'(busy), '0);
      repeat (5) @(negedge clk);
      chk("ss_idle_wait", 128'({busy, done}), '0);
      start = 1'b1;
      busy_n = 0;
      done_n = 0;
      done_at = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = (k == 50);
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_at = k;
         end
      end
      chk("ss_busy_cycles", 128'(busy_n), 128'(256));
      chk("ss_done_count", 128'(done_n), 128'(1));
      chk("ss_done_at", 128'(done_at), 128'(258));
      chk("ss_freq0", 128'(freq[31:0]), 128'(32'd2_500_000));
      chk("ss_end_idle", 128'(busy), '0);
      mode = 1'b0;
      repeat (50) @(negedge clk);
      chk("pre_reset_busy", 128'(busy), 128'(1));
      rst_ = 1'b0;
      #1;
      chk("async_rst_freq", freq, '0);
      chk("async_rst_flags", 128'({freq_valid, done, busy, ovf}), '0);
      en = 1'b0;
      pat_on = 1'b0;
      hold = '1;
      repeat (5) @(negedge clk);
      rst_ = 1'b1;
      en = 1'b1;
      wait_done("phantom", 600, n);
      chk("phantom_freq", freq, '0);
      chk("phantom_freq6", freq6, '0);
      chk("phantom_valid", 128'(freq_valid), 128'(1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/freq_counter_mc.md
# freq_counter_mc

Multi-channel, parametrised frequency counter for the measurement subsystem. Samples `CHANNELS` asynchronous target signals in the single reference-clock domain, counts rising edges over a fixed power-of-two gate window, and converts each count to hertz. Supports continuous and single-shot modes, per-channel overflow flags and a result-ready pulse. All logic runs on one clock; target inputs are data, not clocks.

## Interface
- `CHANNELS`, 4: number of measured inputs.
- `CNT_W`, 32: edge-counter width per channel.
- `REF_HZ`, 10_000_000: `ref_clk` frequency in Hz.
- `GATE_LOG2`, 16: gate window is 2^GATE_LOG2 `ref_clk` cycles.
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `ref_clk`  in  1  sole clock, rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low aborts any window.
- `mode`  in  1  0 = continuous, 1 = single-shot.
- `start`  in  1  single-shot trigger, sampled in IDLE only.
- `targ_in`  in  CHANNELS  asynchronous target signals.
- `freq`  out  32*CHANNELS  result in Hz; channel i at bits [32i+31:32i].
- `freq_valid`  out  1  high once the first result exists.
- `done`  out  1  one-cycle pulse when `freq` updates.
- `busy`  out  1  high while state is GATE.
- `ovf`  out  CHANNELS  per-channel counter saturation in the last window.

## Operation
- Reset: state IDLE; `freq`, `ovf`, gate counter, edge counters, snapshots and synchronisers all 0. `freq_valid`, `done` and `busy` are 0.
- Each channel has a `SYNC_STAGES` synchroniser, then a rising-edge detector (synced 1, previous 0).
- Edge detection is masked until `SYNC_STAGES+1` cycles after reset release, so an input high at reset never produces a phantom edge.
- States: IDLE, GATE.
  - IDLE→GATE when `en` and (`mode`=0, or `mode`=1 and `start`=1).
  - GATE→GATE at the terminal cycle when `mode`=0 and `en`=1.
  - GATE→IDLE at the terminal cycle when `mode`=1.
  - GATE→IDLE on any cycle `en`=0 (abort).
- In GATE the gate counter runs 0..2^GATE_LOG2−1. The terminal cycle is gate count = 2^GATE_LOG2−1.
- Edge counters increment only in GATE and saturate at 2^CNT_W−1. Saturation sets a sticky per-window overflow bit.
- Terminal cycle:
  - Each count, including an edge detected in that same cycle, moves into a snapshot register together with its overflow bit.
  - Live counters and the gate counter clear.
  - In continuous mode the next window starts the following cycle with no dead time.
- Conversion stage, one cycle after the snapshot: `freq` = (snapshot × REF_HZ) >> GATE_LOG2.
  - Full-width product, truncation toward zero.
  - Saturates to 32'hFFFF_FFFF if the result exceeds 32 bits.
  - `ovf` updates from the snapshot overflow bits.
  - `freq_valid` is set and stays set until reset.
  - `done` pulses.
- Abort (`en` low in GATE): live counters and gate counter clear. No snapshot is taken. `freq`, `ovf` and `freq_valid` hold. No `done`.
- `start` in GATE is ignored. `start` with `en`=0 is ignored.
- A `mode` change during GATE takes effect at the terminal cycle.
- Maximum measurable rate is REF_HZ/2. Each input level must last at least one `ref_clk` cycle. The count is exact for periodic inputs and ±1 edge in general.

## Timing
- Terminal cycle T: snapshot registered at the edge ending T. `freq`, `ovf`, `freq_valid` and `done` are registered at the edge ending T+1, so they are visible during T+2 and `done` is high for that one cycle.
- `busy` rises the cycle after the IDLE→GATE edge. It falls the cycle after the terminal cycle (single-shot) or the abort cycle.
- In continuous mode, results arrive every 2^GATE_LOG2 cycles.
- Input-to-count latency is `SYNC_STAGES`+1 cycles. Edges in transit at the window boundary count in the next window.
- Asynchronous reset mid-window clears everything immediately. No `done`.

## Structure
- `freq_counter_pkg`:
  - state enum (IDLE, GATE);
  - `FREQ_W`=32;
  - product-width constant `CNT_W + $clog2(REF_HZ+1)`;
  - saturation helper function.
- Sub-module `freq_chan`: synchroniser, edge detector, saturating counter and sticky overflow, with snapshot/clear inputs. Instantiated `CHANNELS` times by generate.
- Top level holds the FSM, gate counter, conversion stage and output registers.

## Test plan
Bench overrides: GATE_LOG2=8, REF_HZ=10_000_000.
- Continuous mode, ch0 period 4 cycles, ch1 period 8, ch2 period 2, ch3 constant 0 → per window `freq` = 2_500_000 / 1_250_000 / 5_000_000 / 0, `done` every 256 cycles, `ovf`=0.
- CNT_W=6, ch0 period 2 → count saturates at 63, `ovf[0]`=1, `freq[0]`=2_460_937.
- Single-shot: `start` pulse, ch0 period 4 → exactly one `done` 258 cycles after `start`, `busy` 256 cycles, back in IDLE. A second `start` during GATE is ignored.
- `en` dropped at gate count 100 → no `done`, `freq` holds its prior value, next window counts from 0.
- `targ_in` held high across reset release, then `en`=1 → first window reads 0 Hz.
- Asynchronous reset asserted mid-window → all outputs 0 in the same cycle, `freq_valid`=0.
